aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_sub_word.sv | 11 +
 rtl/aes_key_expander.sv | 125 ++++++++++++
 tb/tb_aes_key_expander.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: key-size encoding, Nk/Nr constants, FSM states, S-box table and xtime helper
package aes_pkg;
  typedef enum logic [1:0] {
    KS_128 = 2'b00,
    KS_192 = 2'b01,
    KS_256 = 2'b10,
    KS_RSV = 2'b11
  } key_size_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DRAIN
  } state_e;
  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: 32-bit SubWord, four parallel combinational S-boxes
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  for (genvar b = 0; b < 4; b++) begin : g_sb
    assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
  end
endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: one-word-per-cycle AES key schedule streaming 128-bit round keys; AES_KEY_EXP_192_256_EN adds AES-192/256
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int KEY_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [1:0]       key_size,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [3:0]       rk_idx,
  output logic [127:0]     rk_data,
  output logic             done
);
`ifdef AES_KEY_EXP_192_256_EN
  localparam int HIST = 8;
`else
  localparam int HIST = 4;
`endif
  state_e r_state, w_next;
  logic [KEY_W-1:0] r_key;
  logic [32*HIST-1:0] r_hist;
  logic [95:0] r_acc;
  logic [5:0] r_i;
  logic [3:0] r_mcnt;
  logic [7:0] r_rcon;
  logic [127:0] r_rk_data;
  logic [3:0] r_rk_idx;
  logic r_rk_valid;
  logic [3:0] w_nk, w_nr;
  logic [31:0] w_prev, w_back, w_rot, w_sub_in, w_sub_out, w_temp, w_new;
  logic w_key_word, w_grp_end, w_last, w_adv, w_accept, w_rcon_use;
  assign w_prev = r_hist[31:0];
  assign w_rot = {w_prev[23:0], w_prev[31:24]};
`ifdef AES_KEY_EXP_192_256_EN
  logic [1:0] r_ks;
  assign w_nk = r_ks == KS_192 ? NK_192 : r_ks == KS_256 ? NK_256 : NK_128;
  assign w_nr = r_ks == KS_192 ? NR_192 : r_ks == KS_256 ? NR_256 : NR_128;
  assign w_back = r_ks == KS_192 ? r_hist[191:160] : r_ks == KS_256 ? r_hist[255:224] : r_hist[127:96];
  assign w_sub_in = r_mcnt == 4'd0 ? w_rot : w_prev;
  assign w_temp = r_mcnt == 4'd0 ? w_sub_out ^ {r_rcon, 24'h0} :
                  (r_ks == KS_256 && r_mcnt == 4'd4) ? w_sub_out : w_prev;
`else
  logic w_unused_ks;
  assign w_unused_ks = ^key_size;
  assign w_nk = NK_128;
  assign w_nr = NR_128;
  assign w_back = r_hist[127:96];
  assign w_sub_in = w_rot;
  assign w_temp = r_mcnt == 4'd0 ? w_sub_out ^ {r_rcon, 24'h0} : w_prev;
`endif
  aes_sub_word u_sub (
    .i_word(w_sub_in),
    .o_word(w_sub_out)
  );
  assign w_key_word = r_i < {2'b00, w_nk};
  assign w_new = w_key_word ? r_key[KEY_W-1 -: 32] : w_back ^ w_temp;
  assign w_grp_end = &r_i[1:0];
  assign w_last = r_i == {w_nr, 2'b11};
  assign w_adv = r_state == S_GEN && !(w_grp_end && r_rk_valid && !rk_ready);
  assign w_accept = r_state == S_IDLE && start;
  assign w_rcon_use = w_adv && !w_key_word && r_mcnt == 4'd0;
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DRAIN && r_rk_valid && rk_ready;
  assign rk_valid = r_rk_valid;
  assign rk_idx = r_rk_idx;
  assign rk_data = r_rk_data;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: drain waits for the final key to be taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_GEN;
      S_GEN:   if (w_adv && w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_rk_valid && rk_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // word generator, history, accumulator and round-key output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key <= '0;
      r_hist <= '0;
      r_acc <= '0;
      r_i <= '0;
      r_mcnt <= '0;
      r_rcon <= 8'h01;
      r_rk_data <= '0;
      r_rk_idx <= '0;
      r_rk_valid <= 1'b0;
`ifdef AES_KEY_EXP_192_256_EN
      r_ks <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_key <= key;
        r_i <= '0;
        r_mcnt <= '0;
        r_rcon <= 8'h01;
`ifdef AES_KEY_EXP_192_256_EN
        r_ks <= key_size;
`endif
      end else if (w_adv) begin
        r_key <= r_key << 32;
        r_hist <= {r_hist[32*HIST-33:0], w_new};
        r_i <= r_i + 6'd1;
        r_mcnt <= r_mcnt == w_nk - 4'd1 ? 4'd0 : r_mcnt + 4'd1;
        if (w_rcon_use) r_rcon <= xtime(r_rcon);
        if (!w_grp_end) r_acc <= {r_acc[63:0], w_new};
      end
      if (w_adv && w_grp_end) begin
        r_rk_data <= {r_acc, w_new};
        r_rk_idx <= r_i[5:2];
        r_rk_valid <= 1'b1;
      end else if (rk_ready) r_rk_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: scoreboard bench with FIPS-197 vectors; AES-192/256 runs need AES_KEY_EXP_192_256_EN
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic rst, start, rk_ready;
  logic [255:0] key;
  logic [1:0] key_size;
  logic busy, rk_valid, done;
  logic [3:0] rk_idx;
  logic [127:0] rk_data;
  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         chk;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic stalled = 1'b0;
  logic [127:0] held_data;
  logic [3:0] held_idx;
  bit ab;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] EXP128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_expander #(.KEY_W(256)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .key_size(key_size),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx),
    .rk_data(rk_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every handshake and checks stall stability
  always @(negedge clk) begin
    exp_t e;
    if (rst) stalled = 1'b0;
    else begin
      if (stalled) begin
        check("stall_valid", rk_valid, 1);
        check("stall_data", rk_data, held_data);
        check("stall_idx", rk_idx, held_idx);
      end
      if (rk_valid && rk_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key: got idx %0d with none expected", rk_idx);
        end else begin
          e = q.pop_front();
          check("rk_idx", rk_idx, e.idx);
          if (e.chk) check("rk_data", rk_data, e.data);
        end
      end
      stalled = rk_valid && !rk_ready;
      held_data = rk_data;
      held_idx = rk_idx;
    end
  end

  task automatic expand(input logic [255:0] k, input logic [1:0] ks, input int nr,
                        input logic [127:0] last, input bit rnd, input int inject_at,
                        input int abort_idx, output bit aborted);
    int cyc = 0;
    bit seen = 0;
    aborted = 0;
    for (int n = 0; n <= nr; n++)
      q.push_back('{idx: 4'(n),
                    data: nr == 10 ? EXP128[n % 11] : (n == nr ? last : k[255:128]),
                    chk: nr == 10 || n == 0 || n == nr});
    key = k;
    key_size = ks;
    rk_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    while (!seen && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
      start = cyc == inject_at;
      if (start) key = ~k;
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (abort_idx >= 0 && rk_valid && rk_idx == 4'(abort_idx)) begin
        aborted = 1;
        return;
      end
      seen = done;
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required within 400", cyc);
    end else begin
      check("done_idx", rk_idx, nr);
      if (!rnd) check("done_cycles", cyc, 4 * nr + 4);
      @(posedge clk);
      #1 check("busy_drop", busy, 0);
      check("queue_empty", q.size(), 0);
    end
  endtask

  task automatic check_reset_state();
    check("rst_busy", busy, 0);
    check("rst_valid", rk_valid, 0);
    check("rst_done", done, 0);
    check("rst_idx", rk_idx, 0);
    check("rst_data", rk_data, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rk_ready = 1'b0;
    key = '0;
    key_size = 2'b00;
    repeat (3) @(posedge clk);
    #1 check_reset_state();
    rst = 1'b0;
    @(posedge clk);
    #1;
    expand(K128, 2'b00, 10, EXP128[10], 0, -1, -1, ab);
    expand(K128, 2'b11, 10, EXP128[10], 1, -1, -1, ab);
    expand(K128, 2'b00, 10, EXP128[10], 0, 10, -1, ab);
`ifdef AES_KEY_EXP_192_256_EN
    expand(K192, 2'b01, 12, 128'he98ba06f448c773c8ecc720401002202, 0, -1, -1, ab);
    expand(K256, 2'b10, 14, 128'hfe4890d1e6188d0b046df344706c631e, 0, -1, -1, ab);
`endif
    expand(K128, 2'b00, 10, EXP128[10], 0, -1, 5, ab);
    rst = 1'b1;
    check("reset_point_reached", ab, 1);
    q.delete();
    repeat (2) @(posedge clk);
    #1 check_reset_state();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check("post_rst_valid", rk_valid, 0);
    end
    expand(K128, 2'b00, 10, EXP128[10], 0, -1, -1, ab);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1);
  end
endmodule
